// File: rtl/mdio_c22_master_if.sv
// Request/completion port of the Clause 22 MDIO master.
// The requester drives the address, direction and write data.
// The MDIO master returns the read data and a one-cycle completion pulse.
interface mdio_c22_master_if;
   logic [15:0] paddr;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [15:0] pwdata;
   logic [15:0] prdata;
   logic        pready;

   modport master (
      output paddr, pwrite, psel, penable, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  paddr, pwrite, psel, penable, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/mdio_c22_master.sv
// Multi-lane IEEE 802.3 Clause 22 MDIO master.
// Each request serialises one read or write frame on lane paddr[15:12]. All lanes share one MDC.
// Each MDC period is DIV clk cycles: MDC is low for the first half and high for the second half.
// Build option MDIO_PRE_SUPPRESS_EN: when defined, the 32-bit preamble is skipped.
module mdio_c22_master #(
   parameter int unsigned DIV  = 10000,
   parameter int unsigned NBUS = 5
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mdc,
   output logic [NBUS-1:0] mdo,
   input  logic [NBUS-1:0] mdi,
   output logic [NBUS-1:0] mdt,
   mdio_c22_master_if.slave apb
);

   localparam int unsigned   DW       = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] HALF     = DW'(DIV / 2);
   localparam logic [DW-1:0] HALF_M1  = DW'(DIV / 2 - 1);
   localparam logic [4:0]    NBUS_W   = 5'(NBUS);

   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, GAP, DONE} state_t;

`ifdef MDIO_PRE_SUPPRESS_EN
   localparam state_t FIRST_ST = HDR;
`else
   localparam state_t FIRST_ST = PRE;
`endif

   state_t            state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [4:0]        bit_q, bit_d;
   logic [31:0]       sh_q, sh_d;
   logic [15:0]       rd_q, rd_d;
   logic [15:0]       prdata_q, prdata_d;
   logic [3:0]        sel_q, sel_d;
   logic              wr_q, wr_d;
   logic              mdc_q, mdc_d;
   logic [NBUS-1:0]   mdo_q, mdo_d;
   logic [NBUS-1:0]   mdt_q, mdt_d;

   logic              mdi_sel;
   logic [4:0]        last_bit;
   logic              bit_start;
   logic              lane_drive;
   logic              lane_val;
   logic              unused_apb;

   assign unused_apb = ^{apb.penable, apb.paddr[6], apb.paddr[0]};

   // Pick the input data of the selected lane.
   always_comb begin
      mdi_sel = 1'b1;
      for (int unsigned i = 0; i < NBUS; i++) begin
         if (sel_q == 4'(i)) mdi_sel = mdi[i];
      end
   end

   // Index of the last bit period in each frame field.
   always_comb begin
      case (state_q)
         PRE:     last_bit = 5'd31;
         HDR:     last_bit = 5'd13;
         TA:      last_bit = 5'd1;
         DATA:    last_bit = 5'd15;
         default: last_bit = 5'd0;
      endcase
   end

   // Next state, bit/divider counters and registered MDIO outputs.
   // The shift register holds ST, OP, PHYAD, REGAD, TA and data as one 32-bit word, MSB first.
   // For a read, the TA and data positions are loaded with ones, so mdo stays high while released.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      rd_d      = rd_q;
      prdata_d  = prdata_q;
      sel_d     = sel_q;
      wr_d      = wr_q;
      mdo_d     = mdo_q;
      mdt_d     = mdt_q;
      bit_start = 1'b0;

      case (state_q)
         IDLE: begin
            if (apb.psel) begin
               sel_d = apb.paddr[15:12];
               wr_d  = apb.pwrite;
               sh_d  = {2'b01, (apb.pwrite ? 2'b01 : 2'b10), apb.paddr[11:7], apb.paddr[5:1],
                        (apb.pwrite ? 2'b10 : 2'b11), (apb.pwrite ? apb.pwdata : 16'hFFFF)};
               div_d = '0;
               bit_d = '0;
               if ({1'b0, apb.paddr[15:12]} >= NBUS_W) begin
                  state_d = DONE;
                  if (!apb.pwrite) prdata_d = 16'hFFFF;
               end else begin
                  state_d   = FIRST_ST;
                  bit_start = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: begin
            if (div_q == DIV_LAST) begin
               div_d     = '0;
               bit_start = 1'b1;
               bit_d     = bit_q + 5'd1;
               if (state_q != PRE) sh_d = {sh_q[30:0], 1'b1};
               if (bit_q == last_bit) begin
                  bit_d = '0;
                  case (state_q)
                     PRE:  state_d = HDR;
                     HDR:  state_d = TA;
                     TA:   state_d = DATA;
                     DATA: state_d = GAP;
                     default: begin
                        state_d = DONE;
                        if (!wr_q) prdata_d = rd_q;
                     end
                  endcase
               end
            end else begin
               div_d = div_q + 1'b1;
               if (div_q == HALF_M1 && state_q == DATA && !wr_q) rd_d = {rd_q[14:0], mdi_sel};
            end
         end
      endcase

      mdc_d = (state_d inside {PRE, HDR, TA, DATA, GAP}) && (div_d >= HALF);

      lane_drive = (state_d == PRE) || (state_d == HDR) ||
                   (wr_d && (state_d == TA || state_d == DATA));
      lane_val   = (state_d == PRE) ? 1'b1 : (lane_drive ? sh_d[31] : 1'b1);

      if (bit_start) begin
         mdo_d = '1;
         mdt_d = '1;
         for (int unsigned i = 0; i < NBUS; i++) begin
            if (sel_d == 4'(i)) begin
               mdo_d[i] = lane_val;
               mdt_d[i] = !lane_drive;
            end
         end
      end
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         rd_q     <= '0;
         prdata_q <= '0;
         sel_q    <= '0;
         wr_q     <= 1'b0;
         mdc_q    <= 1'b0;
         mdo_q    <= '1;
         mdt_q    <= '1;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         rd_q     <= rd_d;
         prdata_q <= prdata_d;
         sel_q    <= sel_d;
         wr_q     <= wr_d;
         mdc_q    <= mdc_d;
         mdo_q    <= mdo_d;
         mdt_q    <= mdt_d;
      end
   end

   assign mdc        = mdc_q;
   assign mdo        = mdo_q;
   assign mdt        = mdt_q;
   assign apb.prdata = prdata_q;
   assign apb.pready = (state_q == DONE);

endmodule

// File: tb/tb_mdio_c22_master.sv
// Scoreboard bench for mdio_c22_master (DIV=4, NBUS=5) with a PHY model on every lane.
// Define MDIO_PRE_SUPPRESS_EN for both the RTL and this bench to check preamble suppression.
module tb_mdio_c22_master;
   localparam int unsigned DIV  = 4;
   localparam int unsigned NBUS = 5;
`ifdef MDIO_PRE_SUPPRESS_EN
   localparam int unsigned PRE_BITS = 0;
`else
   localparam int unsigned PRE_BITS = 32;
`endif
   localparam int unsigned NB_FRAME = PRE_BITS + 33;
   localparam int unsigned DSTART   = PRE_BITS + 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            mdc;
   logic [NBUS-1:0] mdo;
   logic [NBUS-1:0] mdt;
   logic [NBUS-1:0] mdi = '1;

   mdio_c22_master_if apb ();

   mdio_c22_master #(.DIV(DIV), .NBUS(NBUS)) dut (
      .clk (clk),
      .rst (rst),
      .mdc (mdc),
      .mdo (mdo),
      .mdi (mdi),
      .mdt (mdt),
      .apb (apb)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int unsigned acc;
      int unsigned lat;
      int unsigned nb;
      logic [15:0] prd;
      logic [64:0] mdo;
      logic [64:0] mdt;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur_e;
   int unsigned cyc      = 0;
   int unsigned n_cmp    = 0;
   int unsigned n_fail   = 0;
   int unsigned frame_id = 0;
   int unsigned cap_id   = 0;
   int unsigned nbits    = 0;
   int unsigned cur_lane = 0;
   logic [15:0] bfm_data = '0;
   logic [64:0] cap_mdo  = '0;
   logic [64:0] cap_mdt  = '0;
   logic        mdc_prev = 1'b0;
   logic        other_bad = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [64:0] lowmask(input int unsigned n);
      lowmask = (n >= 65) ? {65{1'b1}} : ((65'd1 << n) - 65'd1);
   endfunction

   // PHY model: records every bit on the selected lane at MDC rise, supplies read data,
   // and flags any activity on the other lanes.
   always @(negedge clk) begin
      if (frame_id != cap_id) begin
         cap_id    <= frame_id;
         nbits     <= 0;
         cap_mdo   <= '0;
         cap_mdt   <= '0;
         other_bad <= 1'b0;
         mdc_prev  <= mdc;
         mdi       <= '1;
      end else begin
         mdc_prev <= mdc;
         if (mdc === 1'b1 && mdc_prev === 1'b0) begin
            nbits <= nbits + 1;
            if (cur_lane < NBUS) begin
               cap_mdo <= {cap_mdo[63:0], mdo[cur_lane]};
               cap_mdt <= {cap_mdt[63:0], mdt[cur_lane]};
            end
            for (int unsigned i = 0; i < NBUS; i++) begin
               mdi[i] <= (i == cur_lane && nbits + 1 >= DSTART && nbits + 1 < DSTART + 16) ?
                         bfm_data[DSTART + 15 - (nbits + 1)] : 1'b1;
            end
         end
         for (int unsigned i = 0; i < NBUS; i++) begin
            if (i != cur_lane && (mdt[i] !== 1'b1 || mdo[i] !== 1'b1)) other_bad <= 1'b1;
         end
      end
   end

   // Monitor: every completion pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      if (apb.pready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pready: got pready=1 at cycle %0d, expected no pending request", cyc);
         end else begin
            cur_e = exp_q.pop_front();
            chk({cur_e.name, "_latency"}, 65'(cyc + 1 - cur_e.acc), 65'(cur_e.lat));
            chk({cur_e.name, "_prdata"},  65'(apb.prdata), 65'(cur_e.prd));
            chk({cur_e.name, "_mdc_bits"}, 65'(nbits), 65'(cur_e.nb));
            chk({cur_e.name, "_mdo_frame"}, cap_mdo, cur_e.mdo);
            chk({cur_e.name, "_mdt_frame"}, cap_mdt, cur_e.mdt);
            chk({cur_e.name, "_other_lanes"}, 65'(other_bad), 65'd0);
         end
      end
   end

   // Called on a falling edge. b2b means the DUT is in its completion cycle and accepts one edge later.
   task automatic issue(input string name, input logic [3:0] bus, input logic [4:0] phy,
                        input logic [4:0] rg, input logic wr, input logic [15:0] wd,
                        input logic [15:0] rdv, input logic [15:0] prd, input logic [31:0] lo32,
                        input logic [64:0] mdt_exp, input bit b2b);
      exp_t e;
      apb.paddr   = {bus, phy, 1'b0, rg, 1'b0};
      apb.pwrite  = wr;
      apb.pwdata  = wd;
      apb.psel    = 1'b1;
      apb.penable = 1'b1;
      bfm_data    = rdv;
      cur_lane    = 32'(bus);
      frame_id++;
      e.name = name;
      e.acc  = cyc + (b2b ? 2 : 1);
      e.prd  = prd;
      if (bus < NBUS) begin
         e.nb  = NB_FRAME;
         e.lat = NB_FRAME * DIV + 1;
         e.mdo = {32'hFFFF_FFFF, lo32, 1'b1} & lowmask(NB_FRAME);
         e.mdt = mdt_exp;
      end else begin
         e.nb  = 0;
         e.lat = 1;
         e.mdo = '0;
         e.mdt = '0;
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name);
      for (int unsigned k = 0; k < 1000 && apb.pready !== 1'b1; k++) @(negedge clk);
      if (apb.pready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: got no pready within 1000 cycles, expected pready=1", name);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_mdc"},    65'(mdc), 65'd0);
      chk({name, "_mdo"},    65'(mdo), 65'h1F);
      chk({name, "_mdt"},    65'(mdt), 65'h1F);
      chk({name, "_prdata"}, 65'(apb.prdata), 65'd0);
      chk({name, "_pready"}, 65'(apb.pready), 65'd0);
   endtask

   initial begin
      apb.paddr   = '0;
      apb.pwrite  = 1'b0;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      apb.pwdata  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // Write, lane 1, PHYAD 2, REGAD 1E, data A001.
      issue("wr1", 4'd1, 5'd2, 5'h1E, 1'b1, 16'hA001, 16'h0000, 16'h0000, 32'h517A_A001, 65'h1, 1'b0);
      @(negedge clk);
      apb.psel = 1'b0;
      wait_done("wr1");
      @(negedge clk);

      // Read, lane 4, PHYAD 1, REGAD 1F; the PHY returns 1234.
      issue("rd4", 4'd4, 5'd1, 5'h1F, 1'b0, 16'h0000, 16'h1234, 16'h1234, 32'h60FF_FFFF, 65'h7FFFF, 1'b0);
      @(negedge clk);
      apb.psel = 1'b0;
      wait_done("rd4");
      @(negedge clk);

      // Back-to-back with psel held: write (prdata holds 1234), then read, then write.
      issue("b2b_wr", 4'd0, 5'd3, 5'h02, 1'b1, 16'hA003, 16'h0000, 16'h1234, 32'h518A_A003, 65'h1, 1'b0);
      @(negedge clk);
      wait_done("b2b_wr");
      issue("b2b_rd", 4'd2, 5'd5, 5'h10, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, 32'h62C3_FFFF, 65'h7FFFF, 1'b1);
      @(negedge clk);
      wait_done("b2b_rd");
      issue("b2b_wr2", 4'd3, 5'h1F, 5'h00, 1'b1, 16'h0F0F, 16'h0000, 16'h5A5A, 32'h5F82_0F0F, 65'h1, 1'b1);
      @(negedge clk);
      wait_done("b2b_wr2");
      apb.psel = 1'b0;
      @(negedge clk);

      // Invalid bus select 5, read.
      issue("inv5", 4'd5, 5'd1, 5'h01, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 32'h0, 65'h0, 1'b0);
      @(negedge clk);
      apb.psel = 1'b0;
      wait_done("inv5");
      @(negedge clk);

      // Reset in the middle of the data field of a write.
      issue("abort", 4'd1, 5'd2, 5'h1E, 1'b1, 16'hA001, 16'h0000, 16'h0000, 32'h517A_A001, 65'h1, 1'b0);
      @(negedge clk);
      apb.psel = 1'b0;
      repeat ((DSTART + 5) * DIV) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_idle("abort_rst");
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk_idle("abort_hold");
      rst = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_pready", 65'(apb.pready), 65'd0);
      end

      // A fresh write after reset must produce a complete frame; prdata is back to 0.
      issue("after_rst", 4'd1, 5'd2, 5'h1E, 1'b1, 16'hA001, 16'h0000, 16'h0000, 32'h517A_A001, 65'h1, 1'b0);
      @(negedge clk);
      apb.psel = 1'b0;
      wait_done("after_rst");
      @(negedge clk);
      @(negedge clk);

      chk("queue_empty", 65'(exp_q.size()), 65'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
